// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter: two-master IDLE/ACCESS sequencer for the single-port data memory
// define RISCV_ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin
module riscv_dmem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arb_m0_req,
    input  logic              i_arb_m0_wen,
    input  logic [XLEN-1:0]   i_arb_m0_addr,
    input  logic [XLEN-1:0]   i_arb_m0_wr_data,
    input  logic [XLEN/8-1:0] i_arb_m0_byte_sel,
    output logic              o_arb_m0_gnt,
    output logic              o_arb_m0_rd_valid,
    output logic [XLEN-1:0]   o_arb_m0_rd_data,
    input  logic              i_arb_m1_req,
    input  logic              i_arb_m1_wen,
    input  logic [XLEN-1:0]   i_arb_m1_addr,
    input  logic [XLEN-1:0]   i_arb_m1_wr_data,
    input  logic [XLEN/8-1:0] i_arb_m1_byte_sel,
    output logic              o_arb_m1_gnt,
    output logic              o_arb_m1_rd_valid,
    output logic [XLEN-1:0]   o_arb_m1_rd_data,
    output logic [XLEN-1:0]   o_arb_dmem_addr,
    output logic              o_arb_dmem_wen,
    output logic [XLEN-1:0]   o_arb_dmem_wr_data,
    output logic [XLEN/8-1:0] o_arb_dmem_byte_sel,
    input  logic [XLEN-1:0]   i_arb_dmem_rd_data
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state;
    logic              win;
    logic              win_q;
    logic              wen_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wr_data_q;
    logic [XLEN/8-1:0] byte_sel_q;
    logic              acc;
`ifdef RISCV_ARB_FIXED_PRIO_EN
    assign win = ~i_arb_m0_req;
`else
    logic last_gnt;
    assign win = (i_arb_m0_req & i_arb_m1_req) ? ~last_gnt : i_arb_m1_req;
`endif
    assign acc                 = (state == ACCESS);
    assign o_arb_m0_gnt        = acc & ~win_q;
    assign o_arb_m1_gnt        = acc & win_q;
    assign o_arb_dmem_addr     = acc ? addr_q : '0;
    assign o_arb_dmem_wr_data  = acc ? wr_data_q : '0;
    assign o_arb_dmem_byte_sel = acc ? byte_sel_q : '0;
    // a reset landing on the ACCESS cycle must not let the write reach memory
    assign o_arb_dmem_wen      = acc & wen_q & ~i_rst;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            win_q             <= 1'b0;
            wen_q             <= 1'b0;
            addr_q            <= '0;
            wr_data_q         <= '0;
            byte_sel_q        <= '0;
            o_arb_m0_rd_valid <= 1'b0;
            o_arb_m1_rd_valid <= 1'b0;
            o_arb_m0_rd_data  <= '0;
            o_arb_m1_rd_data  <= '0;
`ifndef RISCV_ARB_FIXED_PRIO_EN
            last_gnt          <= 1'b1;
`endif
        end else begin
            o_arb_m0_rd_valid <= 1'b0;
            o_arb_m1_rd_valid <= 1'b0;
            if (state == IDLE) begin
                if (i_arb_m0_req | i_arb_m1_req) begin
                    state      <= ACCESS;
                    win_q      <= win;
                    wen_q      <= win ? i_arb_m1_wen : i_arb_m0_wen;
                    addr_q     <= win ? i_arb_m1_addr : i_arb_m0_addr;
                    wr_data_q  <= win ? i_arb_m1_wr_data : i_arb_m0_wr_data;
                    byte_sel_q <= win ? i_arb_m1_byte_sel : i_arb_m0_byte_sel;
`ifndef RISCV_ARB_FIXED_PRIO_EN
                    last_gnt   <= win;
`endif
                end
            end else begin
                state <= IDLE;
                if (!wen_q) begin
                    if (win_q) begin
                        o_arb_m1_rd_data  <= i_arb_dmem_rd_data;
                        o_arb_m1_rd_valid <= 1'b1;
                    end else begin
                        o_arb_m0_rd_data  <= i_arb_dmem_rd_data;
                        o_arb_m0_rd_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter: randomized two-master traffic against a memory/arbitration reference model
module tb_riscv_dmem_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        req [2];
    logic        wen [2];
    logic [31:0] addr [2];
    logic [31:0] wr_data [2];
    logic [3:0]  sel [2];
    logic        gnt0, gnt1, rv0, rv1, d_wen;
    logic [31:0] rd0, rd1, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel;
    logic [31:0] dmem [64];
    logic [31:0] ref_mem [64];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    typedef struct {
        logic        m;
        logic [31:0] d;
        int          due;
    } rd_t;
    rd_t         rdq[$];
    logic [1:0]  prev_req;
    logic        prev_gnt, last_w, w, exp_any, exp_v, act_v;
    logic [31:0] act_d;
    logic [31:0] last_rd [2];

    riscv_dmem_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_arb_m0_req(req[0]), .i_arb_m0_wen(wen[0]), .i_arb_m0_addr(addr[0]),
        .i_arb_m0_wr_data(wr_data[0]), .i_arb_m0_byte_sel(sel[0]),
        .o_arb_m0_gnt(gnt0), .o_arb_m0_rd_valid(rv0), .o_arb_m0_rd_data(rd0),
        .i_arb_m1_req(req[1]), .i_arb_m1_wen(wen[1]), .i_arb_m1_addr(addr[1]),
        .i_arb_m1_wr_data(wr_data[1]), .i_arb_m1_byte_sel(sel[1]),
        .o_arb_m1_gnt(gnt1), .o_arb_m1_rd_valid(rv1), .o_arb_m1_rd_data(rd1),
        .o_arb_dmem_addr(d_addr), .o_arb_dmem_wen(d_wen), .o_arb_dmem_wr_data(d_wdata),
        .o_arb_dmem_byte_sel(d_sel), .i_arb_dmem_rd_data(d_rdata)
    );

    always #5 i_clk = ~i_clk;
    assign d_rdata = dmem[d_addr[7:2]];

    function automatic logic [31:0] init_word(int i);
        logic [31:0] x;
        x = (32'h01010101 * i) ^ 32'h5A5A0000;
        return (i == 12) ? 32'hA5A5A5A5 : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // memory behind the arbiter: combinational read, byte-masked write at the clock edge
    initial begin
        logic       cw;
        logic [5:0] ci;
        logic [31:0] cd;
        logic [3:0] cs;
        for (int i = 0; i < 64; i++) dmem[i] = init_word(i);
        forever begin
            @(negedge i_clk);
            cw = d_wen; ci = d_addr[7:2]; cd = d_wdata; cs = d_sel;
            @(posedge i_clk);
            if (cw) for (int b = 0; b < 4; b++) if (cs[b]) dmem[ci][8*b+:8] = cd[8*b+:8];
        end
    end

    // monitor/scoreboard: predicts grants from the request history and reads from the reference memory
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        prev_req = 2'b00; prev_gnt = 1'b0; last_w = 1'b1; last_rd[0] = '0; last_rd[1] = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                chk("dmem_wen_in_reset", 32'(d_wen), 32'd0);
                prev_req = 2'b00; prev_gnt = 1'b0; last_w = 1'b1;
                last_rd[0] = '0; last_rd[1] = '0;
                rdq.delete();
            end else begin
                exp_any = (prev_req != 2'b00) && !prev_gnt;
`ifdef RISCV_ARB_FIXED_PRIO_EN
                w = (prev_req == 2'b11) ? 1'b0 : prev_req[1];
`else
                w = (prev_req == 2'b11) ? !last_w : prev_req[1];
`endif
                chk("gnt", {30'd0, gnt1, gnt0}, exp_any ? (w ? 32'd2 : 32'd1) : 32'd0);
                if (exp_any) begin
                    chk("dmem_addr", d_addr, addr[w]);
                    chk("dmem_wen", 32'(d_wen), 32'(wen[w]));
                    chk("dmem_wr_data", d_wdata, wr_data[w]);
                    chk("dmem_byte_sel", 32'(d_sel), 32'(sel[w]));
                    if (wen[w]) begin
                        for (int b = 0; b < 4; b++)
                            if (sel[w][b]) ref_mem[addr[w][7:2]][8*b+:8] = wr_data[w][8*b+:8];
                    end else begin
                        rdq.push_back('{w, ref_mem[addr[w][7:2]], cyc + 1});
                    end
                    last_w = w;
                end else begin
                    chk("dmem_idle", d_addr | d_wdata | 32'(d_sel) | 32'(d_wen), 32'd0);
                end
                for (int m = 0; m < 2; m++) begin
                    act_v = (m == 1) ? rv1 : rv0;
                    act_d = (m == 1) ? rd1 : rd0;
                    exp_v = (rdq.size() > 0) && (rdq[0].due == cyc) && (rdq[0].m == m[0]);
                    chk((m == 1) ? "m1_rd_valid" : "m0_rd_valid", 32'(act_v), 32'(exp_v));
                    if (exp_v) begin
                        chk((m == 1) ? "m1_rd_data" : "m0_rd_data", act_d, rdq[0].d);
                        last_rd[m] = rdq[0].d;
                    end else begin
                        chk((m == 1) ? "m1_rd_data_hold" : "m0_rd_data_hold", act_d, last_rd[m]);
                    end
                end
                if (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
                prev_req = {req[1], req[0]};
                prev_gnt = exp_any;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_req(input int m, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        logic got;
        got = 1'b0;
        req[m] = 1'b1; wen[m] = we; addr[m] = a; wr_data[m] = d; sel[m] = s;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge i_clk);
            got = (m == 1) ? gnt1 : gnt0;
        end
        chk("gnt_within_bound", 32'(got), 32'd1);
        @(posedge i_clk);
        #1 req[m] = 1'b0;
    endtask

    // each master holds its request until granted, then re-raises with probability p percent
    task automatic run_random(input int n, input int p);
        logic [1:0] gs;
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            gs = {gnt1, gnt0};
            @(posedge i_clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (gs[m] || !req[m]) begin
                    if ($urandom_range(99) < p) begin
                        req[m] = 1'b1;
                        wen[m] = 1'($urandom_range(1));
                        addr[m] = 32'($urandom_range(255, 64));
                        wr_data[m] = $urandom;
                        sel[m] = 4'($urandom_range(15));
                    end else begin
                        req[m] = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; wen[m] = 1'b0; addr[m] = '0; wr_data[m] = '0; sel[m] = '0;
        end
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        idle(3);
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        idle(2);
        chk("m1_rd_data_after_write", rd1, 32'hDEADBEEF);
        run_random(30, 100);
        run_random(12, 0);
        idle(3);
        req[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h20; wr_data[1] = 32'h12345678; sel[1] = 4'hF;
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        req[1] = 1'b0;
        @(negedge i_clk);
        chk("dmem_wen_reset_in_access", 32'(d_wen), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        idle(3);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        idle(2);
        chk("m0_rd_after_aborted_write", rd0, init_word(8));
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0);
        do_req(0, 1'b1, 32'h30, 32'h11223344, 4'hF);
        idle(3);
        chk("m0_rd_data_held_after_write", rd0, 32'hA5A5A5A5);
        do_req(1, 1'b1, 32'h31, 32'hFFFFFFFF, 4'h0);
        do_req(1, 1'b0, 32'h31, 32'h0, 4'h0);
        idle(2);
        chk("sel0_write_noop", rd1, 32'h11223344);
        run_random(400, 60);
        run_random(20, 0);
        idle(4);
        chk("reads_drained", 32'(rdq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
